// File: rtl/object_table_reader_if.sv
// Bundle of the object table reader's control, table-read and record-stream
// signals. The master side is the reader; the slave side is the surrounding
// system (labeler control, merge/data tables, record consumer).
interface object_table_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int OBJ_WIDTH  = 128
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  num_labels;
    logic [ADDR_WIDTH-1:0]  tbl_r_addr;
    logic [ADDR_WIDTH-1:0]  merge_data;
    logic [3*OBJ_WIDTH-1:0] data_out;
    logic                   busy;
    logic                   done;
    logic                   obj_valid;
    logic                   obj_ready;
    logic [ADDR_WIDTH-1:0]  obj_label;
    logic [OBJ_WIDTH-1:0]   obj_area;
    logic [OBJ_WIDTH-1:0]   obj_sum_x;
    logic [OBJ_WIDTH-1:0]   obj_sum_y;

    modport master (
        input  start, num_labels, merge_data, data_out, obj_ready,
        output tbl_r_addr, busy, done, obj_valid,
               obj_label, obj_area, obj_sum_x, obj_sum_y
    );

    modport slave (
        output start, num_labels, merge_data, data_out, obj_ready,
        input  tbl_r_addr, busy, done, obj_valid,
               obj_label, obj_area, obj_sum_x, obj_sum_y
    );
endinterface

// File: rtl/object_table_reader.sv
// Object table reader: after a frame, walks labels 1..num_labels-1 through the
// merge and data tables and streams one record per root label with nonzero area.
// Optional macro OBJ_MIN_AREA_FILTER_EN additionally drops roots whose area is
// below MIN_AREA.
module object_table_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int OBJ_WIDTH  = 128,
    parameter int MIN_AREA   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    object_table_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_LABEL = ADDR_WIDTH'(1);

`ifdef OBJ_MIN_AREA_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] label_q, label_d;
    logic [OBJ_WIDTH-1:0]  area_q, area_d;
    logic [OBJ_WIDTH-1:0]  sum_x_q, sum_x_d;
    logic [OBJ_WIDTH-1:0]  sum_y_q, sum_y_d;

    logic [OBJ_WIDTH-1:0]  rd_area;
    logic                  area_ok;
    logic                  keep;
    logic                  at_last;

    // Entry qualification from the current table read-out
    always_comb begin
        rd_area = bus.data_out[OBJ_WIDTH-1:0];
        area_ok = !FILTER_ON || (rd_area >= OBJ_WIDTH'(MIN_AREA));
        keep    = (bus.merge_data == idx_q) && (rd_area != '0) && area_ok;
        at_last = (idx_q == last_q);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= FIRST_LABEL;
            last_q  <= '0;
            addr_q  <= '0;
            label_q <= '0;
            area_q  <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            label_q <= label_d;
            area_q  <= area_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
        end
    end

    // Next-state: scan sequencing, address advance and record capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        label_d = label_q;
        area_d  = area_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // num_labels==0 wraps to all-ones: the full table is in use
                    last_d = bus.num_labels - FIRST_LABEL;
                    idx_d  = FIRST_LABEL;
                    if (bus.num_labels == FIRST_LABEL) begin
                        state_d = FIN;
                    end else begin
                        addr_d  = FIRST_LABEL;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  state_d = CHECK;
            CHECK: begin
                if (keep) begin
                    label_d = idx_q;
                    area_d  = rd_area;
                    sum_x_d = bus.data_out[2*OBJ_WIDTH-1:OBJ_WIDTH];
                    sum_y_d = bus.data_out[3*OBJ_WIDTH-1:2*OBJ_WIDTH];
                    state_d = EMIT;
                end else if (at_last) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + FIRST_LABEL;
                    addr_d  = idx_q + FIRST_LABEL;
                    state_d = ISSUE;
                end
            end
            EMIT: begin
                if (bus.obj_ready) begin
                    if (at_last) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + FIRST_LABEL;
                        addr_d  = idx_q + FIRST_LABEL;
                        state_d = ISSUE;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered record
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == FIN);
        bus.obj_valid  = (state_q == EMIT);
        bus.tbl_r_addr = addr_q;
        bus.obj_label  = label_q;
        bus.obj_area   = area_q;
        bus.obj_sum_x  = sum_x_q;
        bus.obj_sum_y  = sum_y_q;
    end

endmodule

// File: tb/tb_object_table_reader.sv
// Directed bench for object_table_reader: table RAM model, record capture and
// hand-built scan scenarios.
module tb_object_table_reader;
    localparam int AW = 8;
    localparam int OW = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    object_table_reader_if #(.ADDR_WIDTH(AW), .OBJ_WIDTH(OW)) bus();

    object_table_reader #(.ADDR_WIDTH(AW), .OBJ_WIDTH(OW), .MIN_AREA(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Merge and data tables: synchronous read, one cycle latency
    logic [AW-1:0] merge_mem [256];
    logic [OW-1:0] a_mem [256];
    logic [OW-1:0] x_mem [256];
    logic [OW-1:0] y_mem [256];

    always @(posedge clk) begin
        bus.merge_data <= merge_mem[bus.tbl_r_addr];
        bus.data_out   <= {y_mem[bus.tbl_r_addr], x_mem[bus.tbl_r_addr], a_mem[bus.tbl_r_addr]};
    end

    // Record and done-pulse capture, mid-cycle
    logic [AW-1:0] rec_label [512];
    logic [OW-1:0] rec_area [512];
    logic [OW-1:0] rec_x [512];
    logic [OW-1:0] rec_y [512];
    int rec_n = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.obj_valid && bus.obj_ready && rec_n < 512) begin
                rec_label[rec_n] = bus.obj_label;
                rec_area[rec_n]  = bus.obj_area;
                rec_x[rec_n]     = bus.obj_sum_x;
                rec_y[rec_n]     = bus.obj_sum_y;
                rec_n = rec_n + 1;
            end
            if (bus.done) done_cnt = done_cnt + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] exp_x(input int l, input int a);
        return OW'(a * 100 + l);
    endfunction

    function automatic logic [OW-1:0] exp_y(input int l, input int a);
        return (OW'(l) << 120) | OW'(a * 1000 + l);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 256; i++) begin
            merge_mem[i] = '0;
            a_mem[i]     = '0;
            x_mem[i]     = '0;
            y_mem[i]     = '0;
        end
    endtask

    task automatic set_lbl(input int l, input int m, input int a);
        merge_mem[l] = AW'(m);
        a_mem[l]     = OW'(a);
        x_mem[l]     = exp_x(l, a);
        y_mem[l]     = exp_y(l, a);
    endtask

    task automatic chk_rec(input string tag, input int k, input int l, input int a);
        check({tag, "_label"}, OW'(rec_label[k]), OW'(l));
        check({tag, "_area"},  rec_area[k], OW'(a));
        check({tag, "_sumx"},  rec_x[k], exp_x(l, a));
        check({tag, "_sumy"},  rec_y[k], exp_y(l, a));
    endtask

    // Pulse start and wait (bounded) for the done pulse; busy must be clear after
    task automatic run_scan(input string tag, input int nl, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        bus.num_labels = AW'(nl);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        while (done_cnt == d0 && n < budget) begin
            cyc();
            n++;
        end
        check({tag, "_done_once"}, OW'(done_cnt - d0), OW'(1));
        check({tag, "_busy_clr"}, OW'(bus.busy), OW'(0));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.obj_valid && n < budget) begin
            cyc();
            n++;
        end
        check({tag, "_valid_seen"}, OW'(bus.obj_valid), OW'(1));
    endtask

    initial begin
        int base;
        int lat;
        int bad;
        int d0;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.num_labels = '0;
        bus.obj_ready  = 1'b1;
        clear_tbl();
        repeat (3) cyc();

        // Reset state
        check("rst_busy",  OW'(bus.busy), OW'(0));
        check("rst_done",  OW'(bus.done), OW'(0));
        check("rst_valid", OW'(bus.obj_valid), OW'(0));
        check("rst_addr",  OW'(bus.tbl_r_addr), OW'(0));
        check("rst_label", OW'(bus.obj_label), OW'(0));
        check("rst_area",  bus.obj_area, OW'(0));
        reset = 1'b0;
        cyc();

        // 1: single label (background only) -> no records
        base = rec_n;
        run_scan("t1", 1, 10);
        check("t1_nrec", OW'(rec_n - base), OW'(0));

        // 2: labels 1..3 roots, areas 5/9/20; label 4 root with zero area
        clear_tbl();
        set_lbl(1, 1, 5);
        set_lbl(2, 2, 9);
        set_lbl(3, 3, 20);
        set_lbl(4, 4, 0);
        base = rec_n;
        bus.num_labels = AW'(5);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.obj_valid && lat < 20) begin
            cyc();
            lat++;
        end
        check("t2_first_latency", OW'(lat), OW'(4));
        d0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == d0; i++) cyc();
        check("t2_done", OW'(done_cnt - d0), OW'(1));
        check("t2_nrec", OW'(rec_n - base), OW'(3));
        chk_rec("t2_r0", base + 0, 1, 5);
        chk_rec("t2_r1", base + 1, 2, 9);
        chk_rec("t2_r2", base + 2, 3, 20);

        // 3: label 2 merged into 1 -> labels 1 and 3 only
        clear_tbl();
        set_lbl(1, 1, 6);
        set_lbl(2, 1, 7);
        set_lbl(3, 3, 8);
        base = rec_n;
        run_scan("t3", 4, 40);
        check("t3_nrec", OW'(rec_n - base), OW'(2));
        check("t3_r0_label", OW'(rec_label[base]), OW'(1));
        check("t3_r1_label", OW'(rec_label[base + 1]), OW'(3));
        check("t3_r1_area", rec_area[base + 1], OW'(8));

        // 4: back-pressure for 10 cycles, with a start pulse while busy
        clear_tbl();
        set_lbl(1, 1, 11);
        set_lbl(2, 2, 12);
        set_lbl(3, 3, 13);
        base = rec_n;
        bus.obj_ready = 1'b0;
        bus.num_labels = AW'(4);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_valid("t4", 20);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 5);
            cyc();
            if (!bus.obj_valid || bus.obj_label != AW'(1) || bus.obj_area != OW'(11) ||
                bus.obj_sum_x != exp_x(1, 11) || bus.obj_sum_y != exp_y(1, 11))
                bad++;
        end
        bus.start = 1'b0;
        check("t4_hold_stable", OW'(bad), OW'(0));
        check("t4_no_rec_while_held", OW'(rec_n - base), OW'(0));
        d0 = done_cnt;
        bus.obj_ready = 1'b1;
        for (int i = 0; i < 40 && done_cnt == d0; i++) cyc();
        check("t4_done", OW'(done_cnt - d0), OW'(1));
        check("t4_nrec", OW'(rec_n - base), OW'(3));
        chk_rec("t4_r0", base + 0, 1, 11);
        chk_rec("t4_r2", base + 2, 3, 13);
        repeat (5) cyc();
        check("t4_no_restart", OW'(bus.busy), OW'(0));

        // 5: reset during EMIT
        base = rec_n;
        bus.obj_ready = 1'b0;
        bus.num_labels = AW'(4);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_valid("t5", 20);
        d0 = done_cnt;
        reset = 1'b1;
        cyc();
        check("t5_valid_after_rst", OW'(bus.obj_valid), OW'(0));
        check("t5_busy_after_rst", OW'(bus.busy), OW'(0));
        reset = 1'b0;
        bus.obj_ready = 1'b1;
        repeat (4) cyc();
        check("t5_no_done", OW'(done_cnt - d0), OW'(0));
        check("t5_no_rec", OW'(rec_n - base), OW'(0));
        run_scan("t5b", 4, 40);
        check("t5_rescan_nrec", OW'(rec_n - base), OW'(3));
        chk_rec("t5_rescan_r0", base, 1, 11);

        // 6: area filter boundary, areas 5 and 20
        clear_tbl();
        set_lbl(1, 1, 5);
        set_lbl(2, 2, 20);
        base = rec_n;
        run_scan("t6", 3, 40);
`ifdef OBJ_MIN_AREA_FILTER_EN
        check("t6_nrec", OW'(rec_n - base), OW'(1));
        chk_rec("t6_r0", base, 2, 20);
`else
        check("t6_nrec", OW'(rec_n - base), OW'(2));
        chk_rec("t6_r0", base, 1, 5);
        chk_rec("t6_r1", base + 1, 2, 20);
`endif

        // 7: num_labels=0 means full table; only label 255 is a root
        clear_tbl();
        set_lbl(255, 255, 70);
        base = rec_n;
        run_scan("t7", 0, 1200);
        check("t7_nrec", OW'(rec_n - base), OW'(1));
        chk_rec("t7_r0", base, 255, 70);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
